// File: rtl/systolic_ctrl_tiled.sv
// systolic_ctrl_tiled: sequencing controller for the systolic array datapath.
// Walks the operand SRAM address inside a base/limit window, enables the
// array shift/multiply and indexes output-SRAM write-out over a run-time
// number of result sets. The optional stall freeze is built only when the
// macro SYSTOLIC_CTRL_STALL_EN is defined; otherwise the stall port is ignored.
`timescale 1ns/1ps
module systolic_ctrl_tiled #(
    parameter int ARRAY_SIZE  = 8,
    parameter int ADDR_WIDTH  = 7,
    parameter int SET_WIDTH   = 4,
    parameter int CYCLE_BITS  = 9,
    parameter int MATRIX_BITS = 6
) (
    input  logic                   clk,
    input  logic                   srstn,
    input  logic                   tpu_start,
    input  logic [SET_WIDTH-1:0]   num_sets,
    input  logic [ADDR_WIDTH-1:0]  addr_base,
    input  logic [ADDR_WIDTH-1:0]  addr_max,
    input  logic                   stall,
    output logic                   busy,
    output logic                   sram_write_enable,
    output logic [ADDR_WIDTH-1:0]  addr_serial_num,
    output logic                   alu_start,
    output logic [CYCLE_BITS-1:0]  cycle_num,
    output logic [MATRIX_BITS-1:0] matrix_index,
    output logic [SET_WIDTH-1:0]   data_set,
    output logic                   tpu_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        ROLL = 2'd3
    } state_t;

    // Writes begin once the array pipeline has filled (N+1 ROLL cycles).
    localparam logic [CYCLE_BITS-1:0]  WRITE_START = CYCLE_BITS'(ARRAY_SIZE + 1);
    localparam logic [MATRIX_BITS-1:0] MI_LAST     = MATRIX_BITS'(2 * ARRAY_SIZE - 1);
    localparam logic [MATRIX_BITS-1:0] MI_ONE      = MATRIX_BITS'(1);
    localparam logic [CYCLE_BITS-1:0]  CYC_ONE     = CYCLE_BITS'(1);
    localparam logic [SET_WIDTH-1:0]   SET_ONE     = SET_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_TWO    = ADDR_WIDTH'(2);

    state_t                 state_q;
    logic [SET_WIDTH-1:0]   sets_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [ADDR_WIDTH-1:0]  max_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CYCLE_BITS-1:0]  cycle_q;
    logic [MATRIX_BITS-1:0] mi_q;
    logic [SET_WIDTH-1:0]   ds_q;
    logic                   done_q;

    logic [SET_WIDTH-1:0]   sets_d;
    logic                   stall_eff;
    logic                   roll_fire;
    logic                   write_fire;
    logic                   last_write;

`ifdef SYSTOLIC_CTRL_STALL_EN
    // Stall only has meaning while a run is in progress.
    assign stall_eff = stall & (state_q != IDLE);
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign stall_eff    = 1'b0;
`endif

    // A zero set count still produces one result set.
    assign sets_d     = (num_sets == '0) ? SET_ONE : num_sets;
    assign roll_fire  = (state_q == ROLL) && !stall_eff;
    assign write_fire = roll_fire && (cycle_q >= WRITE_START);
    assign last_write = write_fire && (mi_q == MI_LAST) && (ds_q == sets_q - SET_ONE);

    // Control state machine, address walker and write-out counters.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= IDLE;
            sets_q  <= '0;
            base_q  <= '0;
            max_q   <= '0;
            addr_q  <= '0;
            cycle_q <= '0;
            mi_q    <= '0;
            ds_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tpu_start) begin
                        sets_q  <= sets_d;
                        base_q  <= addr_base;
                        max_q   <= addr_max;
                        addr_q  <= addr_base;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (!stall_eff) begin
                        addr_q  <= base_q + ADDR_ONE;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!stall_eff) begin
                        addr_q  <= base_q + ADDR_TWO;
                        state_q <= ROLL;
                    end
                end
                ROLL: begin
                    if (!stall_eff) begin
                        if (cycle_q != '1) begin
                            cycle_q <= cycle_q + CYC_ONE;
                        end
                        if (addr_q < max_q) begin
                            addr_q <= addr_q + ADDR_ONE;
                        end
                        if (last_write) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            cycle_q <= '0;
                            mi_q    <= '0;
                            ds_q    <= '0;
                        end else if (write_fire) begin
                            if (mi_q == MI_LAST) begin
                                mi_q <= '0;
                                ds_q <= ds_q + SET_ONE;
                            end else begin
                                mi_q <= mi_q + MI_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cycle_q <= '0;
                    mi_q    <= '0;
                    ds_q    <= '0;
                end
            endcase
        end
    end

    assign busy              = (state_q != IDLE);
    assign alu_start         = roll_fire;
    assign sram_write_enable = write_fire;
    assign addr_serial_num   = addr_q;
    assign cycle_num         = cycle_q;
    assign matrix_index      = mi_q;
    assign data_set          = ds_q;
    assign tpu_done          = done_q;

endmodule

// File: tb/tb_systolic_ctrl_tiled.sv
// Testbench for systolic_ctrl_tiled: randomized runs checked cycle by cycle
// against a step-count reference model, plus directed schedule checks.
`timescale 1ns/1ps
module tb_systolic_ctrl_tiled;

    localparam int N    = 8;
    localparam int AW   = 7;
    localparam int SW   = 4;
    localparam int CB   = 9;
    localparam int MB   = 6;
    localparam int MAXC = 1024;
`ifdef SYSTOLIC_CTRL_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          srstn;
    logic          tpu_start;
    logic [SW-1:0] num_sets;
    logic [AW-1:0] addr_base;
    logic [AW-1:0] addr_max;
    logic          stall;
    logic          busy;
    logic          sram_write_enable;
    logic [AW-1:0] addr_serial_num;
    logic          alu_start;
    logic [CB-1:0] cycle_num;
    logic [MB-1:0] matrix_index;
    logic [SW-1:0] data_set;
    logic          tpu_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Packed per-cycle snapshot:
    // [29]busy [28]we [27]alu [26]done [25:19]addr [18:10]cycle [9:4]index [3:0]set
    logic [29:0] obs   [MAXC];
    logic [29:0] exp_t [MAXC];
    bit          stall_plan [MAXC];
    int          exp_len;

    systolic_ctrl_tiled #(
        .ARRAY_SIZE(N), .ADDR_WIDTH(AW), .SET_WIDTH(SW), .CYCLE_BITS(CB), .MATRIX_BITS(MB)
    ) dut (
        .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .num_sets(num_sets),
        .addr_base(addr_base), .addr_max(addr_max), .stall(stall), .busy(busy),
        .sram_write_enable(sram_write_enable), .addr_serial_num(addr_serial_num),
        .alu_start(alu_start), .cycle_num(cycle_num), .matrix_index(matrix_index),
        .data_set(data_set), .tpu_done(tpu_done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [29:0] pack_out();
        return {busy, sram_write_enable, alu_start, tpu_done, addr_serial_num,
                cycle_num, matrix_index, data_set};
    endfunction

    // Operand address after t unstalled steps of a run (0 = LOAD cycle).
    function automatic logic [AW-1:0] addr_after(input int t, input int base, input int amax);
        int a;
        if (t == 0) return AW'(base);
        if (t == 1) return AW'((base + 1) % 128);
        a = (base + 2) % 128;
        for (int j = 0; j < t - 2; j++) if (a < amax) a = a + 1;
        return AW'(a);
    endfunction

    // Reference: a run is a sequence of 3+N+2N*S unstalled steps; each output is a
    // plain function of the step count, and stalled cycles repeat the step.
    task automatic model_job(input int sets_in, input int base, input int amax);
        int s, total, t, c, k, w;
        bit stl;
        logic [29:0] v;
        s = (sets_in == 0) ? 1 : sets_in;
        total = 3 + N + 2 * N * s;
        t = 0;
        c = 1;
        while (t < total && c < MAXC - 1) begin
            stl = STALL_EN && stall_plan[c];
            v = '0;
            v[29] = 1'b1;
            v[25:19] = addr_after(t, base, amax);
            if (t >= 2) begin
                k = t - 2;
                v[18:10] = CB'(k);
                v[27] = !stl;
                if (k >= N + 1) begin
                    w = k - N - 1;
                    v[28] = !stl;
                    v[9:4] = MB'(w % (2 * N));
                    v[3:0] = SW'(w / (2 * N));
                end
            end
            exp_t[c] = v;
            if (!stl) t++;
            c++;
        end
        v = '0;
        v[26] = 1'b1;
        v[25:19] = addr_after(total, base, amax);
        exp_t[c] = v;
        exp_len = c;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drive one run from the start cycle (0) through the expected done cycle.
    task automatic drive_job(input int sets_in, input int base, input int amax, input bit poke);
        tpu_start = 1'b1;
        num_sets  = SW'(sets_in);
        addr_base = AW'(base);
        addr_max  = AW'(amax);
        stall     = stall_plan[0];
        #1 obs[0] = pack_out();
        for (int c = 1; c <= exp_len; c++) begin
            @(posedge clk);
            #1;
            if (poke && c < exp_len) begin
                tpu_start = 1'($urandom_range(1));
                num_sets  = SW'($urandom_range(15));
                addr_base = AW'($urandom_range(127));
                addr_max  = AW'($urandom_range(127));
            end else begin
                tpu_start = 1'b0;
            end
            stall = stall_plan[c];
            #1 obs[c] = pack_out();
        end
        tpu_start = 1'b0;
        stall     = 1'b0;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < MAXC; i++) stall_plan[i] = 1'b0;
    endtask

    task automatic test_reset();
        srstn = 1'b0; tpu_start = 1'b0; num_sets = '0; addr_base = '0; addr_max = '0; stall = 1'b0;
        idle(3);
        tests_run++;
        if (pack_out() !== 30'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", pack_out(), 30'h0);
        end
        tpu_start = 1'b1; num_sets = 4'd2; addr_base = 7'd9; addr_max = 7'd50;
        idle(2);
        tests_run++;
        if (pack_out() !== 30'h0) begin
            tests_failed++;
            $display("FAIL start_in_reset: got %h expected %h", pack_out(), 30'h0);
        end
        tpu_start = 1'b0;
        srstn = 1'b1;
        idle(2);
        tests_run++;
        if (pack_out() !== 30'h0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %h expected %h", pack_out(), 30'h0);
        end
    endtask

    task automatic test_single_set();
        int writes, first_w, last_w, dones;
        clear_plan();
        model_job(1, 0, 127);
        drive_job(1, 0, 127, 1'b0);
        begin
            int bad = -1;
            for (int c = 1; c <= exp_len; c++) if (bad < 0 && obs[c] !== exp_t[c]) bad = c;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL single_trace cycle %0d: got %h expected %h", bad, obs[bad], exp_t[bad]);
            end
        end
        writes = 0; first_w = -1; last_w = -1; dones = 0;
        for (int c = 0; c <= exp_len; c++) begin
            if (obs[c][28]) begin
                writes++;
                if (first_w < 0) first_w = c;
                last_w = c;
            end
            if (obs[c][26] && c > 0) dones++;
        end
        tests_run++;
        if (writes != 16) begin tests_failed++; $display("FAIL single_writes: got %0d expected 16", writes); end
        tests_run++;
        if (first_w != 12 || last_w != 27) begin
            tests_failed++;
            $display("FAIL single_window: got %0d..%0d expected 12..27", first_w, last_w);
        end
        tests_run++;
        if (obs[28][26] !== 1'b1 || obs[28][29] !== 1'b0 || dones != 1) begin
            tests_failed++;
            $display("FAIL single_done: got done=%b busy=%b pulses=%0d expected done=1 busy=0 pulses=1",
                     obs[28][26], obs[28][29], dones);
        end
        tests_run++;
        if (obs[27][25:19] !== 7'd26) begin
            tests_failed++;
            $display("FAIL single_last_addr: got %0d expected 26", obs[27][25:19]);
        end
        idle(3);
    endtask

    task automatic test_multi_set();
        int writes, wraps, max_ds;
        clear_plan();
        model_job(3, 10, 127);
        drive_job(3, 10, 127, 1'b0);
        begin
            int bad = -1;
            for (int c = 1; c <= exp_len; c++) if (bad < 0 && obs[c] !== exp_t[c]) bad = c;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL multi_trace cycle %0d: got %h expected %h", bad, obs[bad], exp_t[bad]);
            end
        end
        writes = 0; wraps = 0; max_ds = 0;
        for (int c = 1; c <= exp_len; c++) begin
            if (obs[c][28]) writes++;
            if (int'(obs[c][3:0]) > max_ds) max_ds = int'(obs[c][3:0]);
            if (c < exp_len && obs[c][28] && obs[c][9:4] == 6'd15 && obs[c+1][28] && obs[c+1][9:4] == 6'd0)
                wraps++;
        end
        tests_run++;
        if (writes != 48 || wraps != 2 || max_ds != 2) begin
            tests_failed++;
            $display("FAIL multi_counts: got writes=%0d wraps=%0d max_set=%0d expected 48 2 2", writes, wraps, max_ds);
        end
        idle(2);
    endtask

    task automatic test_zero_sets_busy_start();
        int writes;
        clear_plan();
        model_job(0, 33, 90);
        drive_job(0, 33, 90, 1'b1);
        begin
            int bad = -1;
            for (int c = 1; c <= exp_len; c++) if (bad < 0 && obs[c] !== exp_t[c]) bad = c;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL zero_sets_trace cycle %0d: got %h expected %h", bad, obs[bad], exp_t[bad]);
            end
        end
        writes = 0;
        for (int c = 1; c <= exp_len; c++) if (obs[c][28]) writes++;
        tests_run++;
        if (writes != 16 || exp_len != 28) begin
            tests_failed++;
            $display("FAIL zero_sets_writes: got %0d writes done@%0d expected 16 done@28", writes, exp_len);
        end
        idle(2);
    endtask

    task automatic test_window();
        clear_plan();
        model_job(1, 120, 125);
        drive_job(1, 120, 125, 1'b0);
        begin
            int bad = -1;
            for (int c = 1; c <= exp_len; c++) if (bad < 0 && obs[c] !== exp_t[c]) bad = c;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL window_trace cycle %0d: got %h expected %h", bad, obs[bad], exp_t[bad]);
            end
        end
        tests_run++;
        if (obs[1][25:19] !== 7'd120 || obs[2][25:19] !== 7'd121 || obs[3][25:19] !== 7'd122) begin
            tests_failed++;
            $display("FAIL window_start: got %0d,%0d,%0d expected 120,121,122",
                     obs[1][25:19], obs[2][25:19], obs[3][25:19]);
        end
        tests_run++;
        if (obs[6][25:19] !== 7'd125 || obs[27][25:19] !== 7'd125 || obs[28][25:19] !== 7'd125) begin
            tests_failed++;
            $display("FAIL window_hold: got %0d,%0d,%0d expected 125,125,125",
                     obs[6][25:19], obs[27][25:19], obs[28][25:19]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int s1, s2, b1, b2, m1, m2;
        clear_plan();
        s1 = $urandom_range(1, 3); b1 = $urandom_range(127); m1 = $urandom_range(127);
        s2 = $urandom_range(0, 3); b2 = $urandom_range(127); m2 = $urandom_range(127);
        model_job(s1, b1, m1);
        drive_job(s1, b1, m1, 1'b0);
        begin
            int bad = -1;
            for (int c = 1; c <= exp_len; c++) if (bad < 0 && obs[c] !== exp_t[c]) bad = c;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL b2b_first cycle %0d: got %h expected %h", bad, obs[bad], exp_t[bad]);
            end
        end
        model_job(s2, b2, m2);
        drive_job(s2, b2, m2, 1'b0);
        begin
            int bad = -1;
            for (int c = 1; c <= exp_len; c++) if (bad < 0 && obs[c] !== exp_t[c]) bad = c;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL b2b_second cycle %0d: got %h expected %h", bad, obs[bad], exp_t[bad]);
            end
        end
        idle(2);
    endtask

    task automatic test_stall();
        int stalled_writes, done_c;
        clear_plan();
        stall_plan[0] = 1'b1;
        for (int c = 19; c < 24; c++) stall_plan[c] = 1'b1;
        model_job(1, 0, 127);
        drive_job(1, 0, 127, 1'b0);
        begin
            int bad = -1;
            for (int c = 1; c <= exp_len; c++) if (bad < 0 && obs[c] !== exp_t[c]) bad = c;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL stall_trace cycle %0d: got %h expected %h", bad, obs[bad], exp_t[bad]);
            end
        end
        stalled_writes = 0;
        for (int c = 19; c < 24; c++) if (obs[c][28]) stalled_writes++;
        done_c = -1;
        for (int c = 1; c <= exp_len; c++) if (done_c < 0 && obs[c][26]) done_c = c;
        tests_run++;
        if (done_c != (STALL_EN ? 33 : 28) || stalled_writes != (STALL_EN ? 0 : 5)) begin
            tests_failed++;
            $display("FAIL stall_timing: got done@%0d writes_in_stall=%0d expected done@%0d writes_in_stall=%0d",
                     done_c, stalled_writes, STALL_EN ? 33 : 28, STALL_EN ? 0 : 5);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_roll();
        tpu_start = 1'b1; num_sets = 4'd2; addr_base = 7'd5; addr_max = 7'd100;
        idle(1);
        tpu_start = 1'b0;
        idle(15);
        tests_run++;
        if (busy !== 1'b1 || alu_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL midroll_running: got busy=%b alu=%b expected 1 1", busy, alu_start);
        end
        srstn = 1'b0;
        idle(1);
        tests_run++;
        if (pack_out() !== 30'h0) begin
            tests_failed++;
            $display("FAIL midroll_reset: got %h expected %h", pack_out(), 30'h0);
        end
        srstn = 1'b1;
        idle(1);
        tests_run++;
        if (pack_out() !== 30'h0) begin
            tests_failed++;
            $display("FAIL midroll_after_release: got %h expected %h", pack_out(), 30'h0);
        end
        idle(1);
    endtask

    task automatic test_random();
        int s, b, m;
        bit poke;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < MAXC; i++) stall_plan[i] = ($urandom_range(3) == 0);
            s = $urandom_range(0, 5);
            b = $urandom_range(127);
            m = $urandom_range(127);
            poke = 1'($urandom_range(1));
            model_job(s, b, m);
            drive_job(s, b, m, poke);
            begin
                int bad = -1;
                for (int c = 1; c <= exp_len; c++) if (bad < 0 && obs[c] !== exp_t[c]) bad = c;
                tests_run++;
                if (bad >= 0) begin
                    tests_failed++;
                    $display("FAIL random_trace job %0d sets=%0d base=%0d max=%0d cycle %0d: got %h expected %h",
                             j, s, b, m, bad, obs[bad], exp_t[bad]);
                end
            end
            idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_multi_set();
        test_zero_sets_busy_start();
        test_window();
        test_back_to_back();
        test_stall();
        test_reset_mid_roll();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
